// File: rtl/imem_pkg.sv
// Shared constants for the instruction-memory port arbiter: bus widths,
// read-owner encoding and the idle (inactive) levels of the SRAM control pins.
package imem_pkg;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RUN_W  = 4;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_LOAD  = 1'b1
    } owner_e;

    localparam logic CEN_OFF = 1'b1;
    localparam logic WEN_OFF = 1'b1;
    localparam logic OEN_OFF = 1'b1;

endpackage

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction SRAM between the fetch stage and the
// loader/debug port, and returns read data one cycle later to the issuing side.
module imem_port_arbiter #(
    parameter int unsigned ADDR_W        = imem_pkg::ADDR_W,
    parameter int unsigned DATA_W        = imem_pkg::DATA_W,
    parameter int unsigned MAX_FETCH_RUN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic              l_lock,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              im_cen,
    output logic              im_wen,
    output logic              im_oen,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_datain,
    input  logic [DATA_W-1:0] im_dataout
);
    import imem_pkg::owner_e;
    import imem_pkg::OWN_FETCH;
    import imem_pkg::OWN_LOAD;
    import imem_pkg::CEN_OFF;
    import imem_pkg::WEN_OFF;
    import imem_pkg::OEN_OFF;
    import imem_pkg::RUN_W;

    localparam logic [RUN_W-1:0] MAX_RUN = RUN_W'(MAX_FETCH_RUN);

    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    owner_e           rd_own_q,  rd_own_d;
    logic             locked_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        f_gnt     = 1'b0;
        l_gnt     = 1'b0;
        im_cen    = CEN_OFF;
        im_wen    = WEN_OFF;
        im_oen    = OEN_OFF;
        im_addr   = '0;
        im_datain = '0;
        run_cnt_d = '0;

        // Grants are gated by rst_n so the pins stay idle for the whole reset pulse.
        if (rst_n) begin
            if (locked_q) begin
                l_gnt = l_req;
            end else if (f_req && l_req) begin
                if (run_cnt_q == MAX_RUN) l_gnt = 1'b1;
                else                      f_gnt = 1'b1;
            end else begin
                f_gnt = f_req;
                l_gnt = l_req;
            end
        end

        if (l_gnt) begin
            im_cen  = 1'b0;
            im_addr = l_addr;
            if (l_we) begin
                im_wen    = 1'b0;
                im_datain = l_wdata;
            end else begin
                im_oen = 1'b0;
            end
        end else if (f_gnt) begin
            im_cen  = 1'b0;
            im_addr = f_addr;
            im_oen  = 1'b0;
        end

        // Counts fetch wins only while the loader is actually waiting.
        if (f_gnt && l_req) begin
            run_cnt_d = (run_cnt_q == MAX_RUN) ? run_cnt_q : run_cnt_q + 1'b1;
        end

        rd_pend_d = f_gnt || (l_gnt && !l_we);
        rd_own_d  = l_gnt ? OWN_LOAD : OWN_FETCH;

        f_rvalid = rst_n && rd_pend_q && (rd_own_q == OWN_FETCH);
        l_rvalid = rst_n && rd_pend_q && (rd_own_q == OWN_LOAD);
        f_rdata  = f_rvalid ? im_dataout : '0;
        l_rdata  = l_rvalid ? im_dataout : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q <= '0;
            rd_pend_q <= 1'b0;
            rd_own_q  <= OWN_FETCH;
            locked_q  <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_d;
            rd_pend_q <= rd_pend_d;
            rd_own_q  <= rd_own_d;
            locked_q  <= l_lock;
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: SRAM model, cycle-level reference
// model compared on every falling edge, plus directed literal checks.
module tb_imem_port_arbiter;

    localparam int AW  = 11;
    localparam int DW  = 32;
    localparam int MAX = 4;

    logic          clk;
    logic          rst_n;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          l_req;
    logic          l_we;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic          l_lock;
    logic          l_gnt;
    logic          l_rvalid;
    logic [DW-1:0] l_rdata;
    logic          im_cen;
    logic          im_wen;
    logic          im_oen;
    logic [AW-1:0] im_addr;
    logic [DW-1:0] im_datain;
    logic [DW-1:0] im_dataout;

    int n_tests = 0;
    int n_fail  = 0;

    imem_port_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .MAX_FETCH_RUN(MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_lock(l_lock), .l_gnt(l_gnt),
        .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .im_cen(im_cen), .im_wen(im_wen), .im_oen(im_oen),
        .im_addr(im_addr), .im_datain(im_datain), .im_dataout(im_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single-port SRAM: one-cycle read latency, junk on the bus when not reading.
    logic [DW-1:0] sram [2048];
    always @(posedge clk) begin
        if (!im_cen && !im_wen) sram[im_addr] <= im_datain;
        if (!im_cen && !im_oen) im_dataout <= sram[im_addr];
        else                    im_dataout <= 32'hA5A5_A5A5;
    end

    // Reference model state
    logic [DW-1:0] exp_mem [2048];
    bit            m_locked;
    int            m_run;
    bit            m_pend;
    bit            m_pown;
    logic [DW-1:0] m_pdata;

    always @(negedge clk) begin
        bit eg_f, eg_l, e_rd;
        if (!rst_n) begin
            check("rst_f_gnt",    64'(f_gnt),    64'd0);
            check("rst_l_gnt",    64'(l_gnt),    64'd0);
            check("rst_f_rvalid", 64'(f_rvalid), 64'd0);
            check("rst_l_rvalid", 64'(l_rvalid), 64'd0);
            check("rst_cen",      64'(im_cen),   64'd1);
            check("rst_wen",      64'(im_wen),   64'd1);
            check("rst_oen",      64'(im_oen),   64'd1);
            check("rst_addr",     64'(im_addr),  64'd0);
            check("rst_datain",   64'(im_datain), 64'd0);
            m_locked = 0;
            m_run    = 0;
            m_pend   = 0;
        end else begin
            eg_f = 0;
            eg_l = 0;
            if (m_locked)              eg_l = l_req;
            else if (f_req && l_req)   begin if (m_run == MAX) eg_l = 1; else eg_f = 1; end
            else                       begin eg_f = f_req; eg_l = l_req; end
            e_rd = eg_f || (eg_l && !l_we);

            check("f_gnt",    64'(f_gnt),    64'(eg_f));
            check("l_gnt",    64'(l_gnt),    64'(eg_l));
            check("f_rvalid", 64'(f_rvalid), 64'(m_pend && !m_pown));
            check("l_rvalid", 64'(l_rvalid), 64'(m_pend && m_pown));
            check("f_rdata",  64'(f_rdata),  64'((m_pend && !m_pown) ? m_pdata : 32'h0));
            check("l_rdata",  64'(l_rdata),  64'((m_pend && m_pown) ? m_pdata : 32'h0));
            check("im_cen",   64'(im_cen),   64'(!(eg_f || eg_l)));
            check("im_wen",   64'(im_wen),   64'(!(eg_l && l_we)));
            check("im_oen",   64'(im_oen),   64'(!e_rd));
            check("im_addr",  64'(im_addr),  64'(eg_l ? l_addr : (eg_f ? f_addr : 11'h0)));
            check("im_datain", 64'(im_datain), 64'((eg_l && l_we) ? l_wdata : 32'h0));

            m_pend = e_rd;
            m_pown = eg_l;
            if (e_rd) m_pdata = exp_mem[eg_l ? l_addr : f_addr];
            if (eg_l && l_we) exp_mem[l_addr] = l_wdata;
            m_run    = (eg_f && l_req) ? ((m_run < MAX) ? m_run + 1 : MAX) : 0;
            m_locked = l_lock;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] starve_pat;
        for (int i = 0; i < 2048; i++) begin
            sram[i]    = 32'h1000 + i;
            exp_mem[i] = 32'h1000 + i;
        end
        rst_n = 1'b0; f_req = 1'b1; f_addr = '0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0; l_lock = 1'b0;
        #2;
        check("lit_reset_f_gnt", 64'(f_gnt), 64'd0);
        check("lit_reset_cen",   64'(im_cen), 64'd1);
        step(); step();
        rst_n = 1'b1; f_req = 1'b0;
        step();

        // Fetch-only stream
        f_req = 1'b1; f_addr = 11'd0;
        @(negedge clk); check("lit_fs_gnt0", 64'(f_gnt), 64'd1);
        step(); f_addr = 11'd1;
        @(negedge clk); check("lit_fs_rd0", 64'(f_rdata), 64'h1000);
        step(); f_addr = 11'd2;
        @(negedge clk); check("lit_fs_rd1", 64'(f_rdata), 64'h1001);
        step(); f_req = 1'b0;
        @(negedge clk);
        check("lit_fs_rd2", 64'(f_rdata), 64'h1002);
        check("lit_fs_lrv", 64'(l_rvalid), 64'd0);
        step();

        // Loader write then read back
        l_req = 1'b1; l_we = 1'b1; l_addr = 11'd5; l_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("lit_lw_cen", 64'(im_cen), 64'd0);
        check("lit_lw_wen", 64'(im_wen), 64'd0);
        check("lit_lw_oen", 64'(im_oen), 64'd1);
        step(); l_we = 1'b0;
        @(negedge clk); check("lit_lr_gnt", 64'(l_gnt), 64'd1);
        step(); l_req = 1'b0;
        @(negedge clk);
        check("lit_lr_valid", 64'(l_rvalid), 64'd1);
        check("lit_lr_data",  64'(l_rdata),  64'hDEAD_BEEF);
        step();

        // Starvation bound: F,F,F,F,L repeating (bit set = loader grant)
        starve_pat = 10'b10000_10000;
        f_req = 1'b1; l_req = 1'b1; l_we = 1'b0; f_addr = 11'd10; l_addr = 11'd20;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("lit_starve_l", 64'(l_gnt), 64'(starve_pat[i]));
            check("lit_starve_f", 64'(f_gnt), 64'(!starve_pat[i]));
            step();
            f_addr = f_addr + 11'd1;
        end
        f_req = 1'b0; l_req = 1'b0;
        step();

        // Lock while fetch is requesting
        f_req = 1'b1; f_addr = 11'd40;
        step();
        l_lock = 1'b1; l_req = 1'b1; l_we = 1'b1; l_addr = 11'd30; l_wdata = 32'h0000_0030;
        @(negedge clk); check("lit_lock_first_f", 64'(f_gnt), 64'd1);
        step();
        @(negedge clk);
        check("lit_lock_f_gnt", 64'(f_gnt), 64'd0);
        check("lit_lock_l_gnt", 64'(l_gnt), 64'd1);
        check("lit_lock_f_rv",  64'(f_rvalid), 64'd1);
        step(); l_req = 1'b0;
        @(negedge clk); check("lit_lock_idle_f", 64'(f_gnt), 64'd0);
        step(); l_req = 1'b1; l_we = 1'b0; l_lock = 1'b0;
        @(negedge clk); check("lit_unlock_l", 64'(l_gnt), 64'd1);
        step();
        @(negedge clk);
        check("lit_unlock_f", 64'(f_gnt), 64'd1);
        check("lit_unlock_lg", 64'(l_gnt), 64'd0);
        step(); f_req = 1'b0; l_req = 1'b0;
        step();

        // Reset in the cycle after a fetch grant
        f_req = 1'b1; f_addr = 11'd3;
        @(negedge clk); check("lit_pre_rst_gnt", 64'(f_gnt), 64'd1);
        step(); rst_n = 1'b0;
        @(negedge clk);
        check("lit_rst_f_rv", 64'(f_rvalid), 64'd0);
        check("lit_rst_cen",  64'(im_cen), 64'd1);
        check("lit_rst_oen",  64'(im_oen), 64'd1);
        step(); step();
        rst_n = 1'b1; f_addr = 11'd4;
        @(negedge clk);
        check("lit_post_rst_gnt", 64'(f_gnt), 64'd1);
        check("lit_post_rst_rv",  64'(f_rvalid), 64'd0);
        step(); f_req = 1'b0;
        @(negedge clk); check("lit_post_rst_rd", 64'(f_rdata), 64'h1004);
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
